// File: rtl/day_if.sv
// Control and status bundle between the day sequencer and its neighbours.
// The master drives the controls; the slave (sequencer) drives the day outputs.
interface day_if;
  logic       run;
  logic       step;
  logic       load;
  logic [2:0] load_day;
  logic [2:0] day;
  logic       day_stb;
  logic       week_wrap;
  logic       load_err;

  modport master (
    output run, step, load, load_day,
    input  day, day_stb, week_wrap, load_err
  );

  modport slave (
    input  run, step, load, load_day,
    output day, day_stb, week_wrap, load_err
  );
endinterface

// File: rtl/day_sequencer.sv
// Generates the Mon..Sun day code for the seven-segment display. The code advances on a
// prescaled tick in RUN, on step rising edges in HOLD, or is loaded directly.
module day_sequencer #(
  parameter int unsigned DIV   = 3,
  parameter int unsigned CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  day_if.slave bus
);

  localparam logic StHold = 1'b0;
  localparam logic StRun  = 1'b1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DIV - 1);
  localparam logic [2:0]       DaySun  = 3'd6;

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q;
  logic [2:0]       day_q, day_d;
  logic             stb_q, stb_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic tick;
  logic step_edge;
  logic advance;
  logic load_ok;
  logic load_bad;

  assign tick      = (state_q == StRun) && (cnt_q == CntLast);
  assign step_edge = bus.step & ~step_q;
  assign advance   = tick | ((state_q == StHold) & step_edge);
  assign load_ok   = bus.load & (bus.load_day != 3'd7);
  assign load_bad  = bus.load & (bus.load_day == 3'd7);

  always_comb begin
    state_d = bus.run ? StRun : StHold;

    // Prescaler runs on the state at the start of the cycle; frozen in HOLD.
    cnt_d = cnt_q;
    if (state_q == StRun) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end else if (bus.run) begin
      cnt_d = '0;
    end
    if (load_ok) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    day_d  = day_q;
    stb_d  = 1'b0;
    wrap_d = 1'b0;
    err_d  = load_bad;
    if (load_ok) begin
      // A legal load swallows any coincident advance and never signals a wrap.
      day_d = bus.load_day;
      stb_d = 1'b1;
    end else if (advance) begin
      day_d  = (day_q == DaySun) ? 3'd0 : day_q + 3'd1;
      stb_d  = 1'b1;
      wrap_d = (day_q == DaySun);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      day_q   <= 3'd0;
      stb_q   <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= bus.step;
      day_q   <= day_d;
      stb_q   <= stb_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.day       = day_q;
  assign bus.day_stb   = stb_q;
  assign bus.week_wrap = wrap_q;
  assign bus.load_err  = err_q;

endmodule

// File: tb/tb_day_sequencer.sv
// Randomised scoreboard bench for day_sequencer; a DIV=3 and a DIV=1 instance share stimulus
// and are checked against a cycle-level reference model.
module tb_day_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, step, load;
  logic [2:0] ld;

  always #5 clk = ~clk;

  day_if bus3 ();
  day_if bus1 ();

  assign bus3.run      = run;
  assign bus3.step     = step;
  assign bus3.load     = load;
  assign bus3.load_day = ld;
  assign bus1.run      = run;
  assign bus1.step     = step;
  assign bus1.load     = load;
  assign bus1.load_day = ld;

  day_sequencer #(.DIV(3), .CNT_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  day_sequencer #(.DIV(1), .CNT_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Expected {day, day_stb, week_wrap, load_err} per edge: [11:6] DIV=3, [5:0] DIV=1.
  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Model state: current day, RUN mode, RUN cycles since cadence restart, last step sample.
  int unsigned m_day[2];
  int unsigned m_elapsed[2];
  bit          m_run[2];
  bit          m_step_prev[2];

  function automatic int unsigned div_of(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // Apply current inputs to the model for the coming edge and queue the result.
  task automatic drive();
    logic [5:0] ex[2];
    for (int k = 0; k < 2; k++) begin
      bit tick, adv, legal, bad, stb, wrap;
      if (!rst_n) begin
        m_day[k] = 0; m_run[k] = 0; m_elapsed[k] = 0; m_step_prev[k] = 0;
        ex[k] = 6'd0;
      end else begin
        tick  = m_run[k] && (((m_elapsed[k] + 1) % div_of(k)) == 0);
        adv   = m_run[k] ? tick : (step && !m_step_prev[k]);
        legal = load && (ld <= 3'd6);
        bad   = load && (ld == 3'd7);
        stb   = 0;
        wrap  = 0;
        if (legal) begin
          m_day[k] = ld;
          stb = 1;
        end else if (adv) begin
          wrap = (m_day[k] == 6);
          m_day[k] = (m_day[k] + 1) % 7;
          stb = 1;
        end
        if (legal) m_elapsed[k] = 0;
        else if (m_run[k]) m_elapsed[k] = m_elapsed[k] + 1;
        else if (run) m_elapsed[k] = 0;
        m_run[k]       = run;
        m_step_prev[k] = step;
        ex[k] = {m_day[k][2:0], stb, wrap, bad};
      end
    end
    exp_q.push_back({ex[0], ex[1]});
    @(negedge clk);
  endtask

  initial begin
    logic [11:0] e;
    logic [5:0]  act[2];
    logic [5:0]  want[2];
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        want[0] = e[11:6];
        want[1] = e[5:0];
        act[0]  = {bus3.day, bus3.day_stb, bus3.week_wrap, bus3.load_err};
        act[1]  = {bus1.day, bus1.day_stb, bus1.week_wrap, bus1.load_err};
        for (int k = 0; k < 2; k++) begin
          n_checks++;
          if (act[k] !== want[k]) begin
            n_fail++;
            $display("FAIL outputs DIV=%0d t=%0t: got day=%0d stb=%b wrap=%b err=%b, expected day=%0d stb=%b wrap=%b err=%b",
                     div_of(k), $time, act[k][5:3], act[k][2], act[k][1], act[k][0],
                     want[k][5:3], want[k][2], want[k][1], want[k][0]);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; load = 1'b0; ld = 3'd0;
    drive();
    drive();
    // Free run from reset release.
    rst_n = 1'b1; run = 1'b1;
    repeat (25) drive();
    // Manual steps in HOLD, each 2 high / 2 low.
    run = 1'b0;
    repeat (3) begin
      step = 1'b1; drive(); drive();
      step = 1'b0; drive(); drive();
    end
    // Steps ignored in RUN.
    run = 1'b1;
    repeat (3) begin
      step = 1'b1; drive();
      step = 1'b0; drive();
    end
    // Loads: legal then illegal.
    load = 1'b1; ld = 3'd5; drive();
    load = 1'b0; repeat (4) drive();
    load = 1'b1; ld = 3'd7; drive();
    load = 1'b0; repeat (6) drive();
    // Mid-operation reset.
    rst_n = 1'b0; drive();
    rst_n = 1'b1;
    repeat (4) drive();
    // Randomised mix, including loads colliding with ticks and step held across reset.
    repeat (2000) begin
      rst_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 2) == 0) step = ~step;
      load = ($urandom_range(0, 7) == 0);
      ld   = 3'($urandom_range(0, 7));
      drive();
    end
    rst_n = 1'b1; load = 1'b0;
    drive();
    drive();
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
